// File: rtl/btb_fetch_pkg.sv
// Shared types and constants for the fetch-side branch target buffer.
package btb_fetch_pkg;

    localparam int          BTB_IDX_W_DEF = 2;
    localparam logic [31:0] PC_INC        = 32'd4;

    // Tag and target are kept at their widest (30 bits); unused tag MSBs stay zero.
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [29:0] target;
    } btb_entry_t;

    function automatic logic [29:0] pc_tag(input logic [31:0] pc, input int idx_w);
        return 30'(pc >> (idx_w + 2));
    endfunction

endpackage

// File: rtl/btb_fetch_if.sv
// Fetch/predictor/MEM-stage signal bundle around the BTB; master is the BTB side.
interface btb_fetch_if;

    logic        pc_stall;
    logic [31:0] if_pc;
    logic [1:0]  if_prindex;
    logic        pr_result;
    logic        btb_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        mem_branch;
    logic [31:0] mem_pc;
    logic        mem_taken;
    logic [31:0] mem_target;
    logic        mem_mispredict;
    logic [31:0] mem_correct_pc;

    modport master (
        input  pc_stall, pr_result, mem_branch, mem_pc, mem_taken,
               mem_target, mem_mispredict, mem_correct_pc,
        output if_pc, if_prindex, btb_hit, pred_taken, pred_target
    );

    modport slave (
        output pc_stall, pr_result, mem_branch, mem_pc, mem_taken,
               mem_target, mem_mispredict, mem_correct_pc,
        input  if_pc, if_prindex, btb_hit, pred_taken, pred_target
    );

endinterface

// File: rtl/btb_fetch_array.sv
// Direct-mapped BTB storage: combinational read port, one synchronous write port.
module btb_array
    import btb_fetch_pkg::*;
#(
    parameter int IDX_W = BTB_IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output btb_entry_t       rd_entry,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  btb_entry_t       wr_entry
);

    localparam int N = 2 ** IDX_W;

    logic [N-1:0] valid_r;
    logic [29:0]  tag_r    [N];
    logic [29:0]  target_r [N];

    // Valid bits: cleared by reset, which also suppresses a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {N{1'b0}};
        end else if (wr_en) begin
            valid_r[wr_idx] <= wr_entry.valid;
        end
    end

    // Tag/target payload needs no reset; valid gates its use.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            tag_r[wr_idx]    <= wr_entry.tag;
            target_r[wr_idx] <= wr_entry.target;
        end
    end

    // Read port sees pre-write contents during a same-cycle write.
    always_comb begin
        rd_entry.valid  = valid_r[rd_idx];
        rd_entry.tag    = tag_r[rd_idx];
        rd_entry.target = target_r[rd_idx];
    end

endmodule

// File: rtl/btb_fetch.sv
// PC register, BTB lookup and next-PC selection; optional counters under BTB_STATS_EN.
module btb_fetch
    import btb_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BTB_IDX_W = BTB_IDX_W_DEF,
    parameter int          STATS_W   = 32
) (
    input  logic               CLK,
    input  logic               RST,
    btb_fetch_if.master        bus
`ifdef BTB_STATS_EN
    ,
    output logic [STATS_W-1:0] stat_lookups,
    output logic [STATS_W-1:0] stat_hits,
    output logic [STATS_W-1:0] stat_mispredicts
`endif
);

    logic [31:0]          pc_r;
    logic [31:0]          pc_next_s;
    logic [BTB_IDX_W-1:0] rd_idx_s;
    logic [BTB_IDX_W-1:0] wr_idx_s;
    btb_entry_t           rd_entry_s;
    btb_entry_t           wr_entry_s;
    logic                 wr_en_s;
    logic                 hit_s;
    logic [31:0]          target_s;
    logic                 redirect_s;
    logic                 unused_s;

    assign rd_idx_s   = pc_r[BTB_IDX_W+1:2];
    assign wr_idx_s   = bus.mem_pc[BTB_IDX_W+1:2];
    assign wr_en_s    = bus.mem_branch & bus.mem_taken & ~RST;
    assign wr_entry_s = '{valid: 1'b1,
                          tag: pc_tag(bus.mem_pc, BTB_IDX_W),
                          target: bus.mem_target[31:2]};
    assign redirect_s = bus.mem_branch & bus.mem_mispredict;
    assign unused_s   = ^bus.mem_target[1:0];

    btb_array #(.IDX_W(BTB_IDX_W)) u_array (
        .clk      (CLK),
        .rst      (RST),
        .rd_idx   (rd_idx_s),
        .rd_entry (rd_entry_s),
        .wr_en    (wr_en_s),
        .wr_idx   (wr_idx_s),
        .wr_entry (wr_entry_s)
    );

    // Zero-cycle lookup against the current fetch PC.
    always_comb begin
        hit_s    = rd_entry_s.valid && (rd_entry_s.tag == pc_tag(pc_r, BTB_IDX_W));
        target_s = 32'd0;
        if (hit_s) begin
            target_s = {rd_entry_s.target, 2'b00};
        end else begin
            target_s = 32'd0;
        end
    end

    // Next-PC priority: redirect, stall, predicted target, sequential.
    always_comb begin
        pc_next_s = pc_r + PC_INC;
        if (redirect_s) begin
            pc_next_s = bus.mem_correct_pc;
        end else if (bus.pc_stall) begin
            pc_next_s = pc_r;
        end else if (hit_s && bus.pr_result) begin
            pc_next_s = target_s;
        end else begin
            pc_next_s = pc_r + PC_INC;
        end
    end

    // Fetch PC register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    assign bus.if_pc       = pc_r;
    assign bus.if_prindex  = pc_r[3:2];
    assign bus.btb_hit     = hit_s;
    assign bus.pred_taken  = hit_s & bus.pr_result;
    assign bus.pred_target = target_s;

`ifdef BTB_STATS_EN
    logic accept_s;
    assign accept_s = ~bus.pc_stall & ~redirect_s;

    // Saturating event counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_lookups     <= {STATS_W{1'b0}};
            stat_hits        <= {STATS_W{1'b0}};
            stat_mispredicts <= {STATS_W{1'b0}};
        end else begin
            if (accept_s && (stat_lookups != {STATS_W{1'b1}})) begin
                stat_lookups <= stat_lookups + STATS_W'(1);
            end
            if (accept_s && hit_s && (stat_hits != {STATS_W{1'b1}})) begin
                stat_hits <= stat_hits + STATS_W'(1);
            end
            if (redirect_s && (stat_mispredicts != {STATS_W{1'b1}})) begin
                stat_mispredicts <= stat_mispredicts + STATS_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_btb_fetch.sv
// Directed scoreboard bench for btb_fetch; expectations queued at drive time, checked after the edge.
module tb_btb_fetch;

    localparam int TB_STATS_W = 3;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    btb_fetch_if bus ();

`ifdef BTB_STATS_EN
    logic [TB_STATS_W-1:0] stat_lookups, stat_hits, stat_mispredicts;
    btb_fetch #(.STATS_W(TB_STATS_W)) dut (
        .CLK(CLK), .RST(RST), .bus(bus.master),
        .stat_lookups(stat_lookups), .stat_hits(stat_hits),
        .stat_mispredicts(stat_mispredicts)
    );
`else
    btb_fetch #(.STATS_W(TB_STATS_W)) dut (.CLK(CLK), .RST(RST), .bus(bus.master));
`endif

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            0: return bus.if_pc;
            1: return {31'd0, bus.btb_hit};
            2: return bus.pred_target;
            3: return {31'd0, bus.pred_taken};
            4: return {30'd0, bus.if_prindex};
`ifdef BTB_STATS_EN
            5: return 32'(stat_lookups);
            6: return 32'(stat_hits);
            7: return 32'(stat_mispredicts);
`endif
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag; e.sel = sel; e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel);
            vectors++;
            assert (o === e.val) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
            end
        end
    endtask

    // Check combinational outputs against the currently driven inputs.
    task automatic now(input string tag, input int sel, input logic [31:0] val);
        #1;
        push(tag, sel, val);
        drain();
    endtask

    // Advance one clock and compare everything queued for after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
        drain();
    endtask

    task automatic clr_mem();
        bus.mem_branch = 1'b0; bus.mem_taken = 1'b0; bus.mem_mispredict = 1'b0;
        bus.mem_pc = 32'd0; bus.mem_target = 32'd0; bus.mem_correct_pc = 32'd0;
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] tgt);
        bus.mem_branch = 1'b1; bus.mem_taken = 1'b1; bus.mem_pc = pc; bus.mem_target = tgt;
    endtask

    task automatic redirect(input logic [31:0] pc);
        bus.mem_branch = 1'b1; bus.mem_mispredict = 1'b1; bus.mem_correct_pc = pc;
    endtask

    initial begin
        RST = 1'b1; bus.pc_stall = 1'b0; bus.pr_result = 1'b0; clr_mem();
        tick();
        push("rst_pc", 0, 32'h0); push("rst_hit", 1, 32'h0); push("rst_taken", 3, 32'h0);
        push("rst_tgt", 2, 32'h0); push("rst_idx", 4, 32'h0);
        drain();
        RST = 1'b0;
        push("seq4", 0, 32'h4); tick();
        push("seq8", 0, 32'h8); tick();
        push("seqC", 0, 32'hC); tick();

        // Train 0x10 -> 0x40 while fetching 0xC
        train(32'h10, 32'h40); push("to10", 0, 32'h10); tick(); clr_mem();
        bus.pr_result = 1'b1;
        now("hit10", 1, 32'h1); now("tgt10", 2, 32'h40); now("ptk10", 3, 32'h1);
        push("jump40", 0, 32'h40); tick();
        now("miss40", 1, 32'h0); now("tgt40", 2, 32'h0);
        redirect(32'h10); push("redir10", 0, 32'h10); tick(); clr_mem();
        bus.pr_result = 1'b0;
        now("hit10_nt", 1, 32'h1); now("ptk10_nt", 3, 32'h0);
        push("seq14", 0, 32'h14); tick();

        // Alias 0x50 -> 0x80 evicts 0x10
        train(32'h50, 32'h80); push("seq18", 0, 32'h18); tick(); clr_mem();
        redirect(32'h10); push("redir10b", 0, 32'h10); tick(); clr_mem();
        now("alias_miss10", 1, 32'h0);
        redirect(32'h50); push("redir50", 0, 32'h50); tick(); clr_mem();
        bus.pr_result = 1'b1;
        now("hit50", 1, 32'h1); now("tgt50", 2, 32'h80);
        push("jump80", 0, 32'h80); tick();

        // Redirect beats stall, then stall holds
        bus.pc_stall = 1'b1; redirect(32'h200);
        push("redir_stall", 0, 32'h200); tick(); clr_mem();
        push("hold", 0, 32'h200); tick();
        bus.pc_stall = 1'b0;

        // Same-cycle update and lookup at 0x24
        redirect(32'h24); push("redir24", 0, 32'h24); tick(); clr_mem();
        train(32'h24, 32'h100);
        now("same_cyc_miss", 1, 32'h0); now("same_idx", 4, 32'h1);
        push("seq28", 0, 32'h28); tick(); clr_mem();
        redirect(32'h24); push("redir24b", 0, 32'h24); tick(); clr_mem();
        now("refetch_hit", 1, 32'h1); now("refetch_tgt", 2, 32'h100);
        push("jump100", 0, 32'h100); tick();

        // Wrap-around and ignored mispredict
        bus.pr_result = 1'b0;
        redirect(32'hFFFF_FFFC); push("redirFFC", 0, 32'hFFFF_FFFC); tick(); clr_mem();
        push("wrap0", 0, 32'h0); tick();
        bus.mem_mispredict = 1'b1; bus.mem_correct_pc = 32'h300;
        push("mp_no_br", 0, 32'h4); tick(); clr_mem();

        // Not-taken branch does not allocate
        bus.mem_branch = 1'b1; bus.mem_pc = 32'h8; bus.mem_target = 32'h400;
        push("nt_seq8", 0, 32'h8); tick(); clr_mem();
        now("nt_no_alloc", 1, 32'h0);

        // Reset wins over a pending update
        RST = 1'b1; train(32'h4, 32'h500);
        push("rst_mid_pc", 0, 32'h0); tick(); clr_mem(); RST = 1'b0;
        push("post_rst4", 0, 32'h4); tick();
        now("rst_drop_upd", 1, 32'h0);
        redirect(32'h24); push("redir24c", 0, 32'h24); tick(); clr_mem();
        now("rst_clr_valid", 1, 32'h0);

`ifdef BTB_STATS_EN
        RST = 1'b1; tick(); RST = 1'b0;
        push("st_clr_l", 5, 32'h0); push("st_clr_h", 6, 32'h0); push("st_clr_m", 7, 32'h0);
        drain();
        bus.pc_stall = 1'b1; train(32'h4, 32'h0); tick(); clr_mem();
        bus.pc_stall = 1'b0; bus.pr_result = 1'b1;
        push("st_p4", 0, 32'h4); tick();
        push("st_p0", 0, 32'h0); tick();
        push("st_p4b", 0, 32'h4); tick();
        push("st_p0b", 0, 32'h0); tick();
        push("st_p4c", 0, 32'h4); tick();
        redirect(32'h200); tick(); clr_mem();
        push("st_look", 5, 32'd5); push("st_hits", 6, 32'd2); push("st_mp", 7, 32'd1);
        drain();
        bus.pr_result = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        push("st_sat", 5, 32'd7); push("st_hits2", 6, 32'd2);
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/btb_fetch.md
Name: btb_fetch

Overview:
- Fetch-side branch target buffer plus PC register.
- Sits directly upstream of the 4-entry 2-bit direction predictor:
  - drives the predictor's fetch index;
  - consumes its taken/not-taken result;
  - selects the next fetch PC.
- Trained from the MEM stage when a BEQ/BNE resolves; applies misprediction redirects.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BTB_IDX_W, 2, index width; entries = 2**BTB_IDX_W, indexed by PC[BTB_IDX_W+1:2].
- STATS_W, 32, width of optional statistics counters.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- pc_stall  in  1  hold PC (hazard/memory wait)
- if_pc  out  32  current fetch PC
- if_prindex  out  2  predictor index, = if_pc[3:2]
- pr_result  in  1  predictor taken bit for if_prindex
- btb_hit  out  1  valid entry with matching tag for if_pc
- pred_taken  out  1  btb_hit & pr_result
- pred_target  out  32  stored target for if_pc (0 when no hit)
- mem_branch  in  1  BEQ/BNE resolving in MEM this cycle
- mem_pc  in  32  PC of resolving branch
- mem_taken  in  1  actual outcome
- mem_target  in  32  computed branch target
- mem_mispredict  in  1  resolved outcome/target differs from prediction carried down pipe
- mem_correct_pc  in  32  redirect PC (target if taken, mem_pc+4 otherwise)

Behaviour:
- Entry contents:
  - valid: 1 bit.
  - tag: PC[31:BTB_IDX_W+2].
  - target: PC[31:2]; low 2 bits are always 00.
- Lookup is combinational on if_pc:
  - btb_hit = valid[idx] & (tag[idx] == if_pc tag).
  - pred_target = {target[idx],2'b00} when btb_hit, else 0.
- Next-PC priority, registered on CLK:
  1. RST: pc <= RESET_PC.
  2. mem_mispredict & mem_branch: pc <= mem_correct_pc. This overrides pc_stall.
  3. pc_stall: pc holds.
  4. pred_taken: pc <= pred_target.
  5. otherwise: pc <= pc + 4, wrapping mod 2^32 (32'hFFFF_FFFC -> 0).
- Update, written at CLK edge, when mem_branch & mem_taken:
  - valid[i] <= 1, tag[i] <= mem_pc tag, target[i] <= mem_target[31:2].
  - Overwrites any alias (direct-mapped).
  - Not-taken branches leave the entry untouched; direction is the predictor's job.
- Update proceeds regardless of pc_stall.
- Same-cycle lookup and update to the same index: lookup sees pre-update contents; the new entry is visible next cycle.
- Reset:
  - All valid bits <= 0; tags/targets need no reset.
  - Outputs after reset: if_pc=RESET_PC, btb_hit=0, pred_taken=0, pred_target=0, if_prindex=RESET_PC[3:2].
  - RST asserted mid-operation wins over every other event in that cycle, including a pending update.
- Latency:
  - Prediction is zero-cycle, same cycle as if_pc.
  - Redirect and update take effect one cycle after the mem_* inputs.
- mem_mispredict without mem_branch is ignored.

Optional Feature:
- Macro: BTB_STATS_EN.
- When defined, adds outputs:
  - stat_lookups: increments when a fetch is accepted (!pc_stall, no redirect).
  - stat_hits: increments on accepted fetch with btb_hit.
  - stat_mispredicts: increments on mem_branch & mem_mispredict.
- All three are STATS_W bits wide, saturating at all-ones, cleared by RST.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - BTB_IDX_W default;
  - btb_entry_t struct {valid, tag, target};
  - the word-aligned PC increment constant (4).
- One natural sub-module, btb_array: entry storage with combinational read port and one synchronous write port. btb_fetch holds the PC register, next-PC mux and stats.

Test Plan:
- Reset: RST=1 one cycle -> if_pc=0, btb_hit=0. Then 3 unstalled cycles -> if_pc 4, 8, C.
- Train then hit:
  - mem_branch=1, mem_taken=1, mem_pc=0x10, mem_target=0x40.
  - When if_pc later reaches 0x10 with pr_result=1 -> btb_hit=1, pred_target=0x40, next if_pc=0x40.
  - Same entry with pr_result=0 -> next if_pc=0x14.
- Alias:
  - Train 0x10 -> 0x40, then 0x50 -> 0x80 (same index 0).
  - Fetch 0x10 -> btb_hit=0. Fetch 0x50 -> hit, target 0x80.
- Redirect beats stall: pc_stall=1 with mem_branch=1, mem_mispredict=1, mem_correct_pc=0x200 -> next if_pc=0x200.
- Same-cycle update/lookup: if_pc=0x24 while training 0x24 -> 0x100 -> btb_hit=0 that cycle; a refetch of 0x24 hits.
- With BTB_STATS_EN: 5 accepted fetches (2 hits) and 1 mispredict -> stat_lookups=5, stat_hits=2, stat_mispredicts=1. With STATS_W=2 and 5 lookups -> stat_lookups saturates at 3.
